// File: rtl/pos_encoder.sv
// Button-driven servo position encoder: debounced up/down/center buttons select a
// signed level -9..+9, encoded to a clamped 10-bit target that pos slews toward.
module pos_encoder #(
   parameter int         DEBOUNCE      = 250000,
   parameter int         RAMP_DIV      = 50000,
   parameter logic [9:0] STEP          = 10'd4,
   parameter logic [9:0] POS_CENTER    = 10'd544,
   parameter logic [9:0] POS_PER_LEVEL = 10'd33,
   parameter logic [9:0] POS_MIN       = 10'd228,
   parameter logic [9:0] POS_MAX       = 10'd830
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_center,
   output logic [9:0] pos,
   output logic [9:0] target,
   output logic       level_sign,
   output logic [3:0] level_mag,
   output logic       settled,
   output logic       press
);

   localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE - 1);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RAMP_DIV - 1);

   localparam logic IDLE = 1'b0;
   localparam logic RAMP = 1'b1;

   localparam logic signed [11:0] CENTER_S = 12'(POS_CENTER);
   localparam logic signed [11:0] PER_S    = 12'(POS_PER_LEVEL);
   localparam logic signed [11:0] MIN_S    = 12'(POS_MIN);
   localparam logic signed [11:0] MAX_S    = 12'(POS_MAX);

   // Button bit order everywhere: 0 = up, 1 = down, 2 = center.
   logic [2:0]      btn_raw, sync_a, sync_b, db_state, db_prev, evt;
   logic [DB_W-1:0] db_cnt [3];

   logic signed [4:0]  level, level_nxt;
   logic [4:0]         level_abs;
   logic signed [11:0] level_ext, raw;
   logic [9:0]         target_nxt, pos_nxt, diff;
   logic [DIV_W-1:0]   div;
   logic               tick, press_nxt, state, state_nxt;

   assign btn_raw = {btn_center, btn_down, btn_up};
   assign evt     = db_state & ~db_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a   <= '0;
         sync_b   <= '0;
         db_state <= '0;
         db_prev  <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync_a  <= btn_raw;
         sync_b  <= sync_a;
         db_prev <= db_state;
         for (int i = 0; i < 3; i++) begin
            if (sync_b[i] == db_state[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_MAX) begin
               db_state[i] <= sync_b[i];
               db_cnt[i]   <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      level_nxt = level;
      press_nxt = 1'b0;
      if (evt[2]) begin
         level_nxt = '0;
         press_nxt = 1'b1;
      end else if (evt[0] && evt[1]) begin
         level_nxt = level;
      end else if (evt[0]) begin
         press_nxt = 1'b1;
         if (level != 5'sd9) level_nxt = level + 5'sd1;
      end else if (evt[1]) begin
         press_nxt = 1'b1;
         if (level != -5'sd9) level_nxt = level - 5'sd1;
      end
   end

   assign level_ext = {{7{level[4]}}, level};
   assign raw       = CENTER_S + PER_S * level_ext;

   always_comb begin
      if (raw < MIN_S)      target_nxt = POS_MIN;
      else if (raw > MAX_S) target_nxt = POS_MAX;
      else                  target_nxt = raw[9:0];
   end

   assign level_abs  = level[4] ? -level : level;
   assign level_sign = level[4];
   assign level_mag  = level_abs[3:0];

   assign tick = (div == DIV_MAX);

   // Step never exceeds the remaining distance, so pos cannot overshoot target.
   always_comb begin
      pos_nxt = pos;
      diff    = '0;
      if (state == RAMP && tick) begin
         if (target > pos) begin
            diff    = target - pos;
            pos_nxt = pos + ((diff < STEP) ? diff : STEP);
         end else if (target < pos) begin
            diff    = pos - target;
            pos_nxt = pos - ((diff < STEP) ? diff : STEP);
         end
      end
      state_nxt = (pos == target) ? IDLE : RAMP;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level   <= '0;
         press   <= 1'b0;
         target  <= POS_CENTER;
         pos     <= POS_CENTER;
         div     <= '0;
         state   <= IDLE;
         settled <= 1'b1;
      end else begin
         level   <= level_nxt;
         press   <= press_nxt;
         target  <= target_nxt;
         pos     <= pos_nxt;
         div     <= tick ? '0 : div + 1'b1;
         state   <= state_nxt;
         settled <= (state_nxt == IDLE) && (pos_nxt == target_nxt);
      end
   end

endmodule

// File: tb/tb_pos_encoder.sv
// Directed bench for pos_encoder with DEBOUNCE=4, RAMP_DIV=2, STEP=4.
module tb_pos_encoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_center = 1'b0;
   logic [9:0] pos, target;
   logic       level_sign, settled, press;
   logic [3:0] level_mag;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pos_encoder #(
      .DEBOUNCE (4),
      .RAMP_DIV (2),
      .STEP     (10'd4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_center (btn_center),
      .pos        (pos),
      .target     (target),
      .level_sign (level_sign),
      .level_mag  (level_mag),
      .settled    (settled),
      .press      (press)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic run_cycles(input int n, output int presses);
      presses = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (press === 1'b1) presses++;
      end
   endtask

   task automatic hold_buttons(input logic up, input logic down, input logic center,
                               input int hi, input int lo, output int presses);
      int p1, p2;
      btn_up = up; btn_down = down; btn_center = center;
      run_cycles(hi, p1);
      btn_up = 1'b0; btn_down = 1'b0; btn_center = 1'b0;
      run_cycles(lo, p2);
      presses = p1 + p2;
   endtask

   // Watches pos until settled at dest; counts any move that differs from a
   // STEP-limited move toward dest.
   task automatic follow_ramp(input logic [9:0] dest, input int budget,
                              output int bad, output logic done);
      logic [9:0] prev, want;
      int used;
      bad = 0; used = 0; prev = pos;
      while (!(settled === 1'b1 && pos === dest) && used < budget) begin
         @(posedge clk); #1;
         used++;
         if (pos !== prev) begin
            if (dest > prev)      want = prev + (((dest - prev) < 10'd4) ? (dest - prev) : 10'd4);
            else if (dest < prev) want = prev - (((prev - dest) < 10'd4) ? (prev - dest) : 10'd4);
            else                  want = prev;
            if (pos !== want) bad++;
            prev = pos;
         end
      end
      done = (settled === 1'b1 && pos === dest);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      tests++; if (pos !== 10'd544) begin fails++; $display("FAIL reset_pos: got %0d expected 544", pos); end
      tests++; if (target !== 10'd544) begin fails++; $display("FAIL reset_target: got %0d expected 544", target); end
      tests++; if (level_mag !== 4'd0) begin fails++; $display("FAIL reset_mag: got %0d expected 0", level_mag); end
      tests++; if (level_sign !== 1'b0) begin fails++; $display("FAIL reset_sign: got %0b expected 0", level_sign); end
      tests++; if (settled !== 1'b1) begin fails++; $display("FAIL reset_settled: got %0b expected 1", settled); end
      tests++; if (press !== 1'b0) begin fails++; $display("FAIL reset_press: got %0b expected 0", press); end
   endtask

   task automatic test_single_up;
      int presses = 0, first = -1, bad = 0;
      logic [9:0] prev, want, first_step;
      logic seen = 1'b0;
      first_step = '0;
      prev = pos;
      btn_up = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (press === 1'b1) begin
            presses++;
            if (first < 0) first = i;
         end
         if (pos !== prev) begin
            if (!seen) begin first_step = pos; seen = 1'b1; end
            want = (prev < 10'd577) ? prev + (((10'd577 - prev) < 10'd4) ? (10'd577 - prev) : 10'd4) : prev;
            if (pos !== want) bad++;
            prev = pos;
         end
         if (i == 10) btn_up = 1'b0;
      end
      tests++; if (presses != 1) begin fails++; $display("FAIL up_press_count: got %0d expected 1", presses); end
      tests++; if (first != 7) begin fails++; $display("FAIL up_press_latency: got %0d expected 7", first); end
      tests++; if (level_mag !== 4'd1) begin fails++; $display("FAIL up_mag: got %0d expected 1", level_mag); end
      tests++; if (level_sign !== 1'b0) begin fails++; $display("FAIL up_sign: got %0b expected 0", level_sign); end
      tests++; if (target !== 10'd577) begin fails++; $display("FAIL up_target: got %0d expected 577", target); end
      tests++; if (first_step !== 10'd548) begin fails++; $display("FAIL up_first_step: got %0d expected 548", first_step); end
      tests++; if (bad != 0) begin fails++; $display("FAIL up_ramp_steps: got %0d bad steps expected 0", bad); end
      tests++; if (pos !== 10'd577) begin fails++; $display("FAIL up_final_pos: got %0d expected 577", pos); end
      tests++; if (settled !== 1'b1) begin fails++; $display("FAIL up_settled: got %0b expected 1", settled); end
   endtask

   task automatic test_glitch;
      int p, total = 0;
      btn_up = 1'b1; run_cycles(2, p); total += p;
      btn_up = 1'b0; run_cycles(10, p); total += p;
      repeat (2) begin
         btn_up = 1'b1; run_cycles(1, p); total += p;
         btn_up = 1'b0; run_cycles(1, p); total += p;
      end
      run_cycles(10, p); total += p;
      tests++; if (total != 0) begin fails++; $display("FAIL glitch_press: got %0d expected 0", total); end
      tests++; if (level_mag !== 4'd1) begin fails++; $display("FAIL glitch_mag: got %0d expected 1", level_mag); end
      tests++; if (target !== 10'd577) begin fails++; $display("FAIL glitch_target: got %0d expected 577", target); end
   endtask

   task automatic test_saturate;
      int p, total = 0, bad;
      logic done;
      rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         hold_buttons(1'b1, 1'b0, 1'b0, 8, 10, p);
         total += p;
      end
      tests++; if (total != 12) begin fails++; $display("FAIL sat_press_count: got %0d expected 12", total); end
      tests++; if (level_mag !== 4'd9) begin fails++; $display("FAIL sat_mag: got %0d expected 9", level_mag); end
      tests++; if (level_sign !== 1'b0) begin fails++; $display("FAIL sat_sign: got %0b expected 0", level_sign); end
      tests++; if (target !== 10'd830) begin fails++; $display("FAIL sat_target: got %0d expected 830", target); end
      follow_ramp(10'd830, 600, bad, done);
      tests++; if (bad != 0) begin fails++; $display("FAIL sat_ramp_steps: got %0d bad steps expected 0", bad); end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL sat_settle_timeout: got %0d expected 830 settled", pos); end
      tests++; if (pos !== 10'd830) begin fails++; $display("FAIL sat_pos: got %0d expected 830", pos); end
   endtask

   task automatic test_center;
      int p, bad;
      logic done;
      hold_buttons(1'b0, 1'b0, 1'b1, 8, 0, p);
      tests++; if (p != 1) begin fails++; $display("FAIL center_press: got %0d expected 1", p); end
      tests++; if (target !== 10'd544) begin fails++; $display("FAIL center_target: got %0d expected 544", target); end
      follow_ramp(10'd544, 600, bad, done);
      tests++; if (level_mag !== 4'd0) begin fails++; $display("FAIL center_mag: got %0d expected 0", level_mag); end
      tests++; if (bad != 0) begin fails++; $display("FAIL center_ramp_steps: got %0d bad steps expected 0", bad); end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL center_settle_timeout: got %0d expected 544 settled", pos); end
      tests++; if (pos !== 10'd544) begin fails++; $display("FAIL center_pos: got %0d expected 544", pos); end
   endtask

   task automatic test_up_down_together;
      int p;
      hold_buttons(1'b1, 1'b1, 1'b0, 8, 10, p);
      tests++; if (p != 0) begin fails++; $display("FAIL updown_press: got %0d expected 0", p); end
      tests++; if (level_mag !== 4'd0) begin fails++; $display("FAIL updown_mag: got %0d expected 0", level_mag); end
      tests++; if (target !== 10'd544) begin fails++; $display("FAIL updown_target: got %0d expected 544", target); end
      tests++; if (settled !== 1'b1) begin fails++; $display("FAIL updown_settled: got %0b expected 1", settled); end
   endtask

   task automatic test_retarget;
      int pu, pd, bad, waited = 0;
      logic done;
      logic [9:0] p0, want;
      btn_up = 1'b1;
      run_cycles(8, pu);
      btn_up = 1'b0; btn_down = 1'b1;
      run_cycles(8, pd);
      btn_down = 1'b0;
      p0 = pos;
      tests++; if (pu != 1 || pd != 1) begin fails++; $display("FAIL retarget_presses: got up %0d down %0d expected 1 and 1", pu, pd); end
      tests++; if (target !== 10'd544) begin fails++; $display("FAIL retarget_target: got %0d expected 544", target); end
      tests++; if (!(p0 > 10'd544)) begin fails++; $display("FAIL retarget_midramp: got pos %0d expected above 544", p0); end
      while (pos === p0 && waited < 10) begin
         @(posedge clk); #1;
         waited++;
      end
      want = p0 - (((p0 - 10'd544) < 10'd4) ? (p0 - 10'd544) : 10'd4);
      tests++; if (pos !== want) begin fails++; $display("FAIL retarget_reverse: got %0d expected %0d", pos, want); end
      follow_ramp(10'd544, 200, bad, done);
      tests++; if (bad != 0) begin fails++; $display("FAIL retarget_ramp_steps: got %0d bad steps expected 0", bad); end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL retarget_settle_timeout: got %0d expected 544 settled", pos); end
   endtask

   task automatic test_reset_mid_ramp;
      int p, waited = 0;
      hold_buttons(1'b1, 1'b0, 1'b0, 8, 0, p);
      while (pos === 10'd544 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      tests++; if (pos === 10'd544) begin fails++; $display("FAIL midramp_start: got %0d expected ramp away from 544", pos); end
      rst = 1'b1;
      @(posedge clk); #1;
      tests++; if (pos !== 10'd544) begin fails++; $display("FAIL midramp_reset_pos: got %0d expected 544", pos); end
      tests++; if (target !== 10'd544) begin fails++; $display("FAIL midramp_reset_target: got %0d expected 544", target); end
      tests++; if (level_mag !== 4'd0) begin fails++; $display("FAIL midramp_reset_mag: got %0d expected 0", level_mag); end
      tests++; if (settled !== 1'b1) begin fails++; $display("FAIL midramp_reset_settled: got %0b expected 1", settled); end
      rst = 1'b0;
      run_cycles(20, p);
      tests++; if (p != 0) begin fails++; $display("FAIL midramp_after_press: got %0d expected 0", p); end
      tests++; if (pos !== 10'd544) begin fails++; $display("FAIL midramp_after_pos: got %0d expected 544", pos); end
   endtask

   initial begin
      test_reset();
      test_single_up();
      test_glitch();
      test_saturate();
      test_center();
      test_up_down_together();
      test_retarget();
      test_reset_mid_ramp();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
